// File: rtl/vmem_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : vmem_scanout
//  Brief    : Display-side raster sequencer. Generates timing counters and
//             scaled framebuffer read addresses, absorbs the 1-cycle vmem
//             read latency and drives aligned hsync/vsync/de/rgb.
//  Revision : 1.0 - initial release
// ============================================================================
module vmem_scanout #(
   parameter int VMEM_ADDRW  = 16,
   parameter int VMEM_WDATAW = 3,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE       = 4,
   parameter bit SYNC_POL    = 1'b0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   en_i,
   output logic [VMEM_ADDRW-1:0]  disp_raddr_o,
   input  logic [VMEM_WDATAW-1:0] disp_rdata_i,
   output logic                   hsync_o,
   output logic                   vsync_o,
   output logic                   de_o,
   output logic [VMEM_WDATAW-1:0] rgb_o,
   output logic                   frame_start_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One extra code point so the sync-end bound never aliases to zero
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0] S_LAST       = SW'(SCALE - 1);
   localparam logic [VMEM_ADDRW-1:0] FB_W = VMEM_ADDRW'(H_ACTIVE / SCALE);

   logic [HW-1:0]         h_cnt;
   logic [VW-1:0]         v_cnt;
   logic [SW-1:0]         sx;
   logic [SW-1:0]         sy;
   logic [VMEM_ADDRW-1:0] fx;
   logic [VMEM_ADDRW-1:0] row_base;

   logic h_wrap, v_wrap, active_s0, hs_s0, vs_s0, first_s0;
   logic act_s1, hs_s1, vs_s1, first_s1;
   logic act_s2, hs_s2, vs_s2, first_s2;

   // Stage-0 decode of the raster position
   always_comb begin
      h_wrap    = (h_cnt == H_LAST);
      v_wrap    = (v_cnt == V_LAST);
      active_s0 = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      hs_s0     = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
      vs_s0     = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
      first_s0  = active_s0 && (h_cnt == '0) && (v_cnt == '0);
   end

   // Raster counters and replicated framebuffer coordinates (no dividers)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt    <= '0;
         v_cnt    <= '0;
         sx       <= '0;
         sy       <= '0;
         fx       <= '0;
         row_base <= '0;
      end else if (!en_i) begin
         h_cnt    <= '0;
         v_cnt    <= '0;
         sx       <= '0;
         sy       <= '0;
         fx       <= '0;
         row_base <= '0;
      end else begin
         if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end

         // Horizontal replication: fx steps once every SCALE visible pixels
         if (h_wrap) begin
            sx <= '0;
            fx <= '0;
         end else if (active_s0) begin
            if (sx == S_LAST) begin
               sx <= '0;
               fx <= fx + 1'b1;
            end else begin
               sx <= sx + 1'b1;
            end
         end

         // Vertical replication: advance a framebuffer row every SCALE lines;
         // the frame wrap lands on a line wrap, so fx clears in the same cycle
         if (h_wrap && v_wrap) begin
            sy       <= '0;
            row_base <= '0;
         end else if (active_s0 && (h_cnt == H_ACT_LAST)) begin
            if (sy == S_LAST) begin
               sy       <= '0;
               row_base <= row_base + FB_W;
            end else begin
               sy <= sy + 1'b1;
            end
         end
      end
   end

   // Read-address stage and flag delay line covering the memory latency
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         disp_raddr_o <= '0;
         act_s1       <= 1'b0;
         hs_s1        <= 1'b0;
         vs_s1        <= 1'b0;
         first_s1     <= 1'b0;
         act_s2       <= 1'b0;
         hs_s2        <= 1'b0;
         vs_s2        <= 1'b0;
         first_s2     <= 1'b0;
      end else if (!en_i) begin
         disp_raddr_o <= '0;
         act_s1       <= 1'b0;
         hs_s1        <= 1'b0;
         vs_s1        <= 1'b0;
         first_s1     <= 1'b0;
         act_s2       <= 1'b0;
         hs_s2        <= 1'b0;
         vs_s2        <= 1'b0;
         first_s2     <= 1'b0;
      end else begin
         if (active_s0) begin
            disp_raddr_o <= row_base + fx;
         end
         act_s1   <= active_s0;
         hs_s1    <= hs_s0;
         vs_s1    <= vs_s0;
         first_s1 <= first_s0;
         act_s2   <= act_s1;
         hs_s2    <= hs_s1;
         vs_s2    <= vs_s1;
         first_s2 <= first_s1;
      end
   end

   // Output register: pixel data meets its delayed timing flags here
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hsync_o       <= ~SYNC_POL;
         vsync_o       <= ~SYNC_POL;
         de_o          <= 1'b0;
         rgb_o         <= '0;
         frame_start_o <= 1'b0;
      end else if (!en_i) begin
         hsync_o       <= ~SYNC_POL;
         vsync_o       <= ~SYNC_POL;
         de_o          <= 1'b0;
         rgb_o         <= '0;
         frame_start_o <= 1'b0;
      end else begin
         hsync_o       <= hs_s2 ? SYNC_POL : ~SYNC_POL;
         vsync_o       <= vs_s2 ? SYNC_POL : ~SYNC_POL;
         de_o          <= act_s2;
         rgb_o         <= act_s2 ? disp_rdata_i : '0;
         frame_start_o <= first_s2;
      end
   end

endmodule
`default_nettype wire

// File: doc/vmem_scanout.md
Name: vmem_scanout

Overview:
- Display-side sequencer for the video memory read port (disp_raddr/disp_rdata).
- Generates raster timing counters and scaled framebuffer read addresses, compensates the vmem 1-cycle synchronous read latency, and emits aligned hsync/vsync/de/rgb to the display PHY.
- Sits beside the core-side vmem write arbiter and is the only driver of the vmem read port.

Parameters:
- VMEM_ADDRW, `VMEM_ADDRW: framebuffer address width.
- VMEM_WDATAW, 3: pixel width (RGB 1:1:1).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SCALE, 4: pixel/line replication factor. H_ACTIVE and V_ACTIVE must be multiples of SCALE. FB_W = H_ACTIVE/SCALE.
- SYNC_POL, 0: active sync level (0 = active-low).

Ports:
- clk_i  in  1  pixel clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  scan enable.
- disp_raddr_o  out  VMEM_ADDRW  vmem read address (registered).
- disp_rdata_i  in  VMEM_WDATAW  vmem read data; valid the cycle after disp_raddr_o.
- hsync_o  out  1  horizontal sync.
- vsync_o  out  1  vertical sync.
- de_o  out  1  data enable (visible pixel).
- rgb_o  out  VMEM_WDATAW  pixel data; 0 when de_o=0.
- frame_start_o  out  1  one-cycle pulse with the first visible pixel of each frame.

Behaviour:
- Reset (async assert, sync release):
  - all counters 0; disp_raddr_o=0, de_o=0, rgb_o=0, frame_start_o=0.
  - hsync_o/vsync_o held at the inactive level (~SYNC_POL).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters).
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, then wraps to 0.
- Decode, from counters (stage 0):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs uses the same form on v_cnt with the V_* parameters.
- Address generation, no dividers:
  - sx counts 0..SCALE-1 across active pixels; fx increments on sx wrap. Both clear at line start.
  - sy counts lines 0..SCALE-1; at sy wrap after the last active pixel of a line, row_base += FB_W.
  - row_base clears at v_cnt wrap.
  - disp_raddr_o <= row_base+fx when active; holds its last value otherwise.
- Pipeline, fixed 3-cycle latency from counter position to outputs:
  - c+1: disp_raddr_o.
  - c+2: disp_rdata_i.
  - c+3: rgb_o.
  - hs, vs, active and first-pixel flags pass through a matching 3-stage delay.
  - Invariant: rgb_o(n) = mem[disp_raddr_o(n-2)] whenever de_o(n)=1.
- Output mapping:
  - hsync_o = hs ? SYNC_POL : ~SYNC_POL; vsync_o is analogous.
  - de_o = delayed active.
  - rgb_o = de_o ? data : 0.
  - frame_start_o = 1 exactly in the cycle de_o is first asserted for h=0, v=0.
- en_i:
  - While en_i=0: counters, sx/sy/fx/row_base and the delay pipeline are synchronously cleared; outputs as in reset.
  - en_i 0->1: scanning begins at h=0, v=0; first de_o/frame_start_o arrives 3 cycles later.
  - en_i dropped mid-frame: outputs return to the reset state one cycle later; no partial-frame resume.
- Boundaries:
  - frame wrap coincides with a line wrap: row_base and fx both clear in the same cycle.
  - SCALE=1: fx advances every pixel.
  - The last address of a frame is FB_W*(V_ACTIVE/SCALE)-1. Addresses never exceed it.

Test Plan:
- Params for the directed tests: H=8/2/2/2, V=4/1/1/1, SCALE=2, FB_W=4. H_TOTAL=14, V_TOTAL=7.
- Reset: assert rst_ni mid-line -> immediately hsync_o=vsync_o=1, de_o=0, rgb_o=0, disp_raddr_o=0.
- Address sequence:
  - en_i=1 from reset -> disp_raddr_o over active lines: 0,0,1,1,2,2,3,3 on lines 0 and 1; 4,4,5,5,6,6,7,7 on lines 2 and 3.
  - Addresses wrap back to 0 on the next frame.
- Latency: fill mem[k]=k%8 -> first de_o 3 cycles after en_i rises, rgb_o=0,0,1,1,2,2,3,3; frame_start_o high only in that first cycle.
- Timing:
  - hsync_o low exactly 2 cycles, starting 10 cycles after the line's first de_o.
  - vsync_o low exactly 14 cycles per frame.
  - frame_start_o period 98 cycles; de_o high 32 cycles per frame.
- en_i mid-frame: drop en_i at v=2,h=5 for 3 cycles -> outputs idle; on re-enable the first pixel is address 0, with frame_start_o 3 cycles later.
- SCALE=1, H_ACTIVE=8, V_ACTIVE=4: addresses 0..31 strictly incrementing per active pixel; rgb_o matches mem.
